// File: rtl/scrambler_arbiter_pkg.sv
// Shared encodings and seeds for the scrambler arbiter and its benches.
// Also holds the two-way round-robin pick used by rr_arbiter2.
package scrambler_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   localparam logic [6:0] SEED_DEFAULT_A = 7'b1011101;
   localparam logic [6:0] SEED_DEFAULT_B = 7'b1111111;

   // On contention the source that was not served last wins.
   function automatic logic [1:0] pick_rr(
      input logic [1:0] req,
      input logic       last_served
   );
      logic [1:0] g;
      g = req;
      if (req == 2'b11)
         g = last_served ? 2'b01 : 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter with a one-hot grant.
// last_served only moves when the owner accepts the grant via en.
import scrambler_arbiter_pkg::*;

module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic last_q;

   assign gnt = pick_rr(req, last_q);

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_q <= 1'b1;
      else if (en && (|gnt))
         last_q <= gnt[1];
   end

endmodule

// File: rtl/scrambler_arbiter.sv
// Shares one scrambler between two frame sources, reseeding it per frame.
// Grant is held from the seed load until the frame's tlast.
import scrambler_arbiter_pkg::*;

module scrambler_arbiter #(
   parameter int WIDTH      = 24,
   parameter int SEED_WIDTH = 7,
   parameter int MAX_BEATS  = 256
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [WIDTH-1:0]      s0_axis_tdata,
   input  logic                  s0_axis_tvalid,
   output logic                  s0_axis_tready,
   input  logic                  s0_axis_tlast,
   input  logic [SEED_WIDTH-1:0] s0_seed,
   input  logic [WIDTH-1:0]      s1_axis_tdata,
   input  logic                  s1_axis_tvalid,
   output logic                  s1_axis_tready,
   input  logic                  s1_axis_tlast,
   input  logic [SEED_WIDTH-1:0] s1_seed,
   output logic [WIDTH-1:0]      m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [SEED_WIDTH-1:0] cfg_seed,
   output logic                  cfg_seed_load,
   output logic [1:0]            grant,
   output logic                  trunc
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

   logic [1:0]            state;
   logic [1:0]            grant_q;
   logic [1:0]            arb_gnt;
   logic [CW-1:0]         beat_cnt;
   logic [SEED_WIDTH-1:0] seed_q;
   logic                  trunc_q;

   logic                  in_idle, in_load, in_stream, in_drain;
   logic                  s_valid, s_last, src_ready;
   logic                  m_hs, s_hs, at_limit;
   logic [WIDTH-1:0]      s_data;

   assign in_idle   = (state == ST_IDLE);
   assign in_load   = (state == ST_LOAD);
   assign in_stream = (state == ST_STREAM);
   assign in_drain  = (state == ST_DRAIN);

   rr_arbiter2 u_arb (
      .clk   (aclk),
      .rst_n (aresetn),
      .req   ({s1_axis_tvalid, s0_axis_tvalid}),
      .en    (in_idle),
      .gnt   (arb_gnt)
   );

   assign s_valid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
   assign s_last  = grant_q[1] ? s1_axis_tlast  : s0_axis_tlast;
   assign s_data  = grant_q[1] ? s1_axis_tdata  : s0_axis_tdata;

   assign at_limit = (beat_cnt == LAST_BEAT);

   // Outputs are gated by aresetn so nothing moves while reset is held.
   assign src_ready = aresetn & ((in_stream & m_axis_tready) | in_drain);
   assign s0_axis_tready = src_ready & grant_q[0];
   assign s1_axis_tready = src_ready & grant_q[1];

   assign m_axis_tvalid = aresetn & in_stream & s_valid;
   assign m_axis_tdata  = s_data;
   assign m_axis_tlast  = in_stream & (s_last | at_limit);

   assign m_hs = m_axis_tvalid & m_axis_tready;
   assign s_hs = s_valid & src_ready;

   assign cfg_seed      = seed_q;
   assign cfg_seed_load = aresetn & in_load;
   assign grant         = grant_q;
   assign trunc         = trunc_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         grant_q  <= 2'b00;
         seed_q   <= '0;
         beat_cnt <= '0;
         trunc_q  <= 1'b0;
      end else begin
         trunc_q <= 1'b0;
         unique case (1'b1)
            in_idle: begin
               if (|arb_gnt) begin
                  grant_q <= arb_gnt;
                  seed_q  <= arb_gnt[1] ? s1_seed : s0_seed;
                  state   <= ST_LOAD;
               end
            end
            in_load: begin
               beat_cnt <= '0;
               state    <= ST_STREAM;
            end
            in_stream: begin
               if (m_hs) begin
                  beat_cnt <= beat_cnt + CW'(1);
                  if (s_last) begin
                     state   <= ST_IDLE;
                     grant_q <= 2'b00;
                  end else if (at_limit) begin
                     trunc_q <= 1'b1;
                     state   <= ST_DRAIN;
                  end
               end
            end
            in_drain: begin
               if (s_hs && s_last) begin
                  state   <= ST_IDLE;
                  grant_q <= 2'b00;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
